// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO bundle: memory read port, pointer exchange and the consumer stream.
// master = the read controller, slave = memory / write domain / consumer.
interface fifo_read_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH:0]   WPTR_GRAY_SYNC;
   logic [ADDR_WIDTH:0]   RPTR_GRAY;
   logic                  R_EN;
   logic [ADDR_WIDTH-1:0] R_ADDR;
   logic [DATA_WIDTH-1:0] RDATA;
   logic                  EMPTY;
   logic [DATA_WIDTH-1:0] DOUT;
   logic                  DOUT_VALID;
   logic                  DOUT_READY;

   modport master (
      input  WPTR_GRAY_SYNC, RDATA, DOUT_READY,
      output RPTR_GRAY, R_EN, R_ADDR, EMPTY, DOUT, DOUT_VALID
   );

   modport slave (
      output WPTR_GRAY_SYNC, RDATA, DOUT_READY,
      input  RPTR_GRAY, R_EN, R_ADDR, EMPTY, DOUT, DOUT_VALID
   );
endinterface

// File: rtl/fifo_read_ctrl.sv
// FIFO read-domain controller: read pointer, empty detection, and a 2-entry buffer that hides
// the memory's registered read latency behind a first-word-fall-through stream.
module fifo_read_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic             RCLK,
  input  logic             RRST_N,
  fifo_read_ctrl_if.master bus
);

   logic [ADDR_WIDTH:0]   rbin_q, rbin_d;
   logic [ADDR_WIDTH:0]   rgray_q, rgray_d;
   logic                  inflight_q;
   logic [1:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

   logic       empty;
   logic       pop;
   logic       r_en;
   logic [2:0] occupancy;

   assign empty = (rgray_q == bus.WPTR_GRAY_SYNC);
   assign pop   = (count_q != 2'd0) & bus.DOUT_READY;

   // Words held or on their way, after this cycle's pop; never exceeds the 2 buffer slots.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign r_en      = RRST_N & ~empty & (occupancy < 3'd2);

   always_comb begin
      rbin_d = rbin_q;
      if (r_en) begin
         rbin_d = rbin_q + 1'b1;
      end
      rgray_d = rbin_d ^ (rbin_d >> 1);
   end

   // buf0 is always the head; buf1 only holds a word while count is 2.
   always_comb begin
      buf0_d  = buf0_q;
      buf1_d  = buf1_q;
      count_d = count_q;
      case ({inflight_q, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               buf0_d = bus.RDATA;
            end else begin
               buf1_d = bus.RDATA;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               buf0_d = buf1_q;
               buf1_d = bus.RDATA;
            end else begin
               buf0_d = bus.RDATA;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge RCLK or negedge RRST_N) begin
      if (!RRST_N) begin
         rbin_q     <= '0;
         rgray_q    <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         rbin_q     <= rbin_d;
         rgray_q    <= rgray_d;
         inflight_q <= r_en;
         count_q    <= count_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

   assign bus.RPTR_GRAY  = rgray_q;
   assign bus.R_EN       = r_en;
   assign bus.R_ADDR     = rbin_q[ADDR_WIDTH-1:0];
   assign bus.EMPTY      = empty;
   assign bus.DOUT       = buf0_q;
   assign bus.DOUT_VALID = (count_q != 2'd0);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized bench for fifo_read_ctrl with a 4-deep memory model and a word-count reference.
module tb_fifo_read_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 2;

   logic RCLK;
   logic RRST_N;

   fifo_read_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .RCLK   (RCLK),
      .RRST_N (RRST_N),
      .bus    (bus)
   );

   initial RCLK = 1'b0;
   always #5 RCLK = ~RCLK;

   logic [DW-1:0] mem [4];
   logic [DW-1:0] data [256];

   // Registered-read memory model.
   always @(posedge RCLK) begin
      if (bus.R_EN) bus.RDATA <= mem[bus.R_ADDR];
   end

   int n_tests;
   int n_fail;

   // Reference counts since the last reset: words written, reads issued, words captured, pops.
   int wr, iss, cap, pops;
   int mode;

   function automatic logic [AW:0] gray(input int b);
      logic [AW:0] v;
      v = b[AW:0];
      return v ^ (v >> 1);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rdy, input int add);
      bit valid_exp, pop_now, ren_exp;
      logic [DW-1:0] w;
      @(negedge RCLK);
      for (int i = 0; i < add; i++) begin
         if (wr - pops < 4) begin
            case (mode)
               1:       w = 8'hA5;
               2:       w = 8'(8'h10 + wr);
               default: w = 8'($urandom);
            endcase
            data[wr]    = w;
            mem[wr % 4] = w;
            wr++;
         end
      end
      bus.WPTR_GRAY_SYNC = gray(wr);
      bus.DOUT_READY     = rdy;
      #1;
      valid_exp = (cap > pops);
      pop_now   = valid_exp && rdy;
      ren_exp   = (wr != iss) && ((iss - pops - int'(pop_now)) < 2);
      check_eq("empty", {31'd0, bus.EMPTY}, {31'd0, wr == iss});
      check_eq("r_en", {31'd0, bus.R_EN}, {31'd0, ren_exp});
      check_eq("rptr_gray", 32'(bus.RPTR_GRAY), 32'(gray(iss)));
      check_eq("dout_valid", {31'd0, bus.DOUT_VALID}, {31'd0, valid_exp});
      if (valid_exp) check_eq("dout", 32'(bus.DOUT), 32'(data[pops]));
      else if (cap == 0) check_eq("dout_reset", 32'(bus.DOUT), 32'd0);
      if (ren_exp) check_eq("r_addr", 32'(bus.R_ADDR), 32'(iss % 4));
      check_eq("occupancy_le2", {31'd0, (iss - pops) <= 2}, 32'd1);
      pops += int'(pop_now);
      cap  = iss;
      iss += int'(ren_exp);
   endtask

   // Asynchronous reset between edges; write domain resets alongside.
   task automatic do_reset();
      @(negedge RCLK);
      #2;
      RRST_N = 1'b0;
      bus.WPTR_GRAY_SYNC = '0;
      #1;
      check_eq("rst_r_en", {31'd0, bus.R_EN}, 32'd0);
      check_eq("rst_valid", {31'd0, bus.DOUT_VALID}, 32'd0);
      check_eq("rst_dout", 32'(bus.DOUT), 32'd0);
      check_eq("rst_rptr", 32'(bus.RPTR_GRAY), 32'd0);
      check_eq("rst_empty", {31'd0, bus.EMPTY}, 32'd1);
      wr = 0; iss = 0; cap = 0; pops = 0;
      repeat (2) @(negedge RCLK);
      RRST_N = 1'b1;
   endtask

   initial begin
      int cyc;
      n_tests = 0; n_fail = 0;
      wr = 0; iss = 0; cap = 0; pops = 0; mode = 0;
      for (int i = 0; i < 4; i++) mem[i] = 8'h5A;
      RRST_N = 1'b0;
      bus.WPTR_GRAY_SYNC = '0;
      bus.DOUT_READY     = 1'b0;
      repeat (2) @(negedge RCLK);
      RRST_N = 1'b1;

      // Idle after reset.
      repeat (3) step(1'b1, 0);

      // Single word.
      mode = 1;
      step(1'b1, 1);
      repeat (4) step(1'b1, 0);

      // Four words preloaded, consumer stalled, then released.
      do_reset();
      mode = 2;
      step(1'b0, 4);
      repeat (5) step(1'b0, 0);
      repeat (6) step(1'b1, 0);

      // Continuous stream across the address wrap.
      do_reset();
      mode = 0;
      cyc = 0;
      while (pops < 10 && cyc < 200) begin
         step(1'b1, (wr < 10) ? 1 : 0);
         cyc++;
      end
      check_eq("stream_done", 32'(pops), 32'd10);

      // Random ready and bursty, lagging writer.
      cyc = 0;
      while (pops < 60 && cyc < 2000) begin
         step(1'($urandom_range(0, 1)), (wr < 60) ? int'($urandom_range(0, 2)) : 0);
         cyc++;
      end
      check_eq("random_done", 32'(pops), 32'd60);

      // Reset with a word in flight and one buffered; nothing stale afterwards.
      do_reset();
      step(1'b0, 3);
      step(1'b0, 0);
      do_reset();
      repeat (4) step(1'b1, 0);
      step(1'b1, 1);
      repeat (4) step(1'b1, 0);
      check_eq("post_reset_word", 32'(pops), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
